devil_ac_filter: RTL and testbench

- Ingress stage on the ACE snoop address (AC) channel, directly upstream of the devil CR-delay/response FSM.
- Accepts AC beats from the interconnect through a 2-entry skid buffer and classifies each beat against the ACSNOOP and BASE_ADDR/MEM_SIZE filters from the CTRL register.
- Forwards the beat plus a match flag to the devil FSM, which decides whether to delay or tamper with the CR response.
- Keeps saturating snoop and match counters for STATUS readback.

---
 rtl/devil_pkg.sv | 30 +++
 rtl/devil_ac_filter_if.sv | 33 +++
 rtl/devil_skid_buf.sv | 79 +++++++
 rtl/devil_ac_filter.sv | 121 ++++++++++++
 tb/tb_devil_ac_filter.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/devil_pkg.sv
// Shared types and constants for the devil snoop-tampering block.
// Holds the ACSNOOP encodings, the buffered AC beat layout and CTRL bit positions.
package devil_pkg;

    localparam int unsigned AC_ADDR_W  = 44;
    localparam int unsigned AC_SNOOP_W = 4;

    localparam logic [AC_SNOOP_W-1:0] READ_ONCE             = 4'd0;
    localparam logic [AC_SNOOP_W-1:0] READ_SHARED           = 4'd1;
    localparam logic [AC_SNOOP_W-1:0] READ_CLEAN            = 4'd2;
    localparam logic [AC_SNOOP_W-1:0] READ_NOT_SHARED_DIRTY = 4'd3;
    localparam logic [AC_SNOOP_W-1:0] READ_UNIQUE           = 4'd7;
    localparam logic [AC_SNOOP_W-1:0] CLEAN_SHARED          = 4'd8;
    localparam logic [AC_SNOOP_W-1:0] CLEAN_INVALID         = 4'd9;
    localparam logic [AC_SNOOP_W-1:0] MAKE_INVALID          = 4'd13;
    localparam logic [AC_SNOOP_W-1:0] DVM_COMPLETE          = 4'd14;
    localparam logic [AC_SNOOP_W-1:0] DVM_MESSAGE           = 4'd15;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_ACFLT_BIT   = 14;
    localparam int unsigned CTRL_ADDRFLT_BIT = 15;

    typedef struct packed {
        logic [AC_ADDR_W-1:0]  addr;
        logic [AC_SNOOP_W-1:0] snoop;
        logic [2:0]            prot;
        logic                  match;
    } ac_beat_t;

endpackage

// File: rtl/devil_ac_filter_if.sv
// AC snoop channel bundle: interconnect-side ingress plus the forwarded beat to the devil FSM.
// The slave modport is the filter's view; master is the driver/environment view.
interface devil_ac_filter_if
    import devil_pkg::*;
#(
    parameter int unsigned ADDR_W  = AC_ADDR_W,
    parameter int unsigned SNOOP_W = AC_SNOOP_W
) ();

    logic               acvalid;
    logic               acready;
    logic [ADDR_W-1:0]  acaddr;
    logic [SNOOP_W-1:0] acsnoop;
    logic [2:0]         acprot;

    logic               o_ac_valid;
    logic               i_ac_ready;
    logic [ADDR_W-1:0]  o_ac_addr;
    logic [SNOOP_W-1:0] o_ac_snoop;
    logic [2:0]         o_ac_prot;
    logic               o_ac_match;

    modport slave (
        input  acvalid, acaddr, acsnoop, acprot, i_ac_ready,
        output acready, o_ac_valid, o_ac_addr, o_ac_snoop, o_ac_prot, o_ac_match
    );

    modport master (
        output acvalid, acaddr, acsnoop, acprot, i_ac_ready,
        input  acready, o_ac_valid, o_ac_addr, o_ac_snoop, o_ac_prot, o_ac_match
    );

endinterface

// File: rtl/devil_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered ready and registered outputs.
// FIFO order; the head entry drives the output and is held stable while stalled.
module devil_skid_buf #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0] state_q, state_d;
    T           head_q, head_d;
    T           tail_q, tail_d;
    logic       ready_q;
    logic       push, pop;

    assign push = in_valid_i & ready_q;
    assign pop  = (state_q != StEmpty) & out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    head_d  = in_data_i;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d  = in_data_i;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // ready is low in FULL, so only a pop can happen here
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (state_d != StFull);
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = head_q;

endmodule

// File: rtl/devil_ac_filter.sv
// AC snoop ingress: skid-buffers beats, tags each with the CTRL filter verdict, keeps counters.
// Optional last-match trace outputs are built when DEVIL_AC_TRACE_EN is defined.
module devil_ac_filter
    import devil_pkg::*;
#(
    parameter int unsigned ADDR_W  = AC_ADDR_W,
    parameter int unsigned SNOOP_W = AC_SNOOP_W,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               i_en,
    input  logic               i_acflt_en,
    input  logic               i_addrflt_en,
    input  logic [SNOOP_W-1:0] i_acsnoop_ref,
    input  logic [31:0]        i_base_addr,
    input  logic [31:0]        i_mem_size,
    input  logic               i_cnt_clr,
    devil_ac_filter_if.slave   ac,
    output logic [CNT_W-1:0]   o_snoop_cnt,
    output logic [CNT_W-1:0]   o_match_cnt
`ifdef DEVIL_AC_TRACE_EN
    ,
    output logic [ADDR_W-1:0]  o_last_match_addr,
    output logic [SNOOP_W-1:0] o_last_match_snoop
`endif
);

    localparam int unsigned     WinW   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [WinW-1:0] addr_x, win_lo, win_hi;
    logic            in_win, match, accept, in_ready, out_valid;
    ac_beat_t        beat_in, beat_out;
    logic [CNT_W-1:0] snoop_cnt_q, snoop_cnt_d, match_cnt_q, match_cnt_d;

    // One extra bit so base + size never wraps back into the address space
    assign addr_x = {1'b0, ac.acaddr};
    assign win_lo = WinW'(i_base_addr);
    assign win_hi = win_lo + WinW'(i_mem_size);
    assign in_win = (addr_x >= win_lo) && (addr_x < win_hi);

    assign match  = i_en & (!i_acflt_en | (ac.acsnoop == i_acsnoop_ref))
                         & (!i_addrflt_en | in_win);
    assign accept = ac.acvalid & in_ready;

    always_comb begin
        beat_in.addr  = ac.acaddr;
        beat_in.snoop = ac.acsnoop;
        beat_in.prot  = ac.acprot;
        beat_in.match = match;
    end

    devil_skid_buf #(
        .T (ac_beat_t)
    ) u_skid (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .in_valid_i  (ac.acvalid),
        .in_ready_o  (in_ready),
        .in_data_i   (beat_in),
        .out_valid_o (out_valid),
        .out_ready_i (ac.i_ac_ready),
        .out_data_o  (beat_out)
    );

    assign ac.acready    = in_ready;
    assign ac.o_ac_valid = out_valid;
    assign ac.o_ac_addr  = beat_out.addr;
    assign ac.o_ac_snoop = beat_out.snoop;
    assign ac.o_ac_prot  = beat_out.prot;
    assign ac.o_ac_match = beat_out.match;

    always_comb begin
        snoop_cnt_d = snoop_cnt_q;
        match_cnt_d = match_cnt_q;
        if (i_cnt_clr) begin
            snoop_cnt_d = '0;
            match_cnt_d = '0;
        end else if (accept) begin
            if (snoop_cnt_q != CntMax) snoop_cnt_d = snoop_cnt_q + CntOne;
            if (match && (match_cnt_q != CntMax)) match_cnt_d = match_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snoop_cnt_q <= '0;
            match_cnt_q <= '0;
        end else begin
            snoop_cnt_q <= snoop_cnt_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign o_snoop_cnt = snoop_cnt_q;
    assign o_match_cnt = match_cnt_q;

`ifdef DEVIL_AC_TRACE_EN
    logic [ADDR_W-1:0]  last_addr_q;
    logic [SNOOP_W-1:0] last_snoop_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_addr_q  <= '0;
            last_snoop_q <= '0;
        end else if (i_cnt_clr) begin
            last_addr_q  <= '0;
            last_snoop_q <= '0;
        end else if (accept && match) begin
            last_addr_q  <= ac.acaddr;
            last_snoop_q <= ac.acsnoop;
        end
    end

    assign o_last_match_addr  = last_addr_q;
    assign o_last_match_snoop = last_snoop_q;
`endif

endmodule

// File: tb/tb_devil_ac_filter.sv
// Bench for devil_ac_filter: queue-based reference model checked every negedge,
// plus directed beats with hand-computed verdicts and counter values.
module tb_devil_ac_filter;

    localparam int unsigned AW = 44;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 8;   // narrow counters so saturation is reachable
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_en, i_acflt_en, i_addrflt_en, i_cnt_clr;
    logic [SW-1:0] i_acsnoop_ref;
    logic [31:0]   i_base_addr, i_mem_size;
    logic [CW-1:0] o_snoop_cnt, o_match_cnt;
`ifdef DEVIL_AC_TRACE_EN
    logic [AW-1:0] o_last_match_addr;
    logic [SW-1:0] o_last_match_snoop;
`endif

    always #5 clk = ~clk;

    devil_ac_filter_if #(.ADDR_W(AW), .SNOOP_W(SW)) ac_if ();

    devil_ac_filter #(
        .ADDR_W  (AW),
        .SNOOP_W (SW),
        .CNT_W   (CW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .i_en          (i_en),
        .i_acflt_en    (i_acflt_en),
        .i_addrflt_en  (i_addrflt_en),
        .i_acsnoop_ref (i_acsnoop_ref),
        .i_base_addr   (i_base_addr),
        .i_mem_size    (i_mem_size),
        .i_cnt_clr     (i_cnt_clr),
        .ac            (ac_if),
        .o_snoop_cnt   (o_snoop_cnt),
        .o_match_cnt   (o_match_cnt)
`ifdef DEVIL_AC_TRACE_EN
        ,
        .o_last_match_addr  (o_last_match_addr),
        .o_last_match_snoop (o_last_match_snoop)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // Reference verdict straight from the filter rules, with 64-bit window arithmetic
    function automatic logic exp_match(input logic [AW-1:0] a, input logic [SW-1:0] s);
        bit [63:0] lo, hi;
        bit        win;
        lo  = 64'(i_base_addr);
        hi  = lo + 64'(i_mem_size);
        win = (64'(a) >= lo) && (64'(a) < hi);
        return i_en && (!i_acflt_en || (s == i_acsnoop_ref)) && (!i_addrflt_en || win);
    endfunction

    // Model: beats held in the DUT, registered ready, counters, trace
    logic [51:0] mq[$];
    logic        ready_m;
    int          scnt_m, mcnt_m;
    logic [AW-1:0] last_a_m;
    logic [SW-1:0] last_s_m;
    logic        acc_m, fwd_m, m_m;

    always @(negedge clk) begin
        if (!resetn) begin
            mq.delete();
            ready_m  = 1'b0;
            scnt_m   = 0;
            mcnt_m   = 0;
            last_a_m = '0;
            last_s_m = '0;
            chk("rst_acready", 64'(ac_if.acready), 64'd0);
            chk("rst_valid", 64'(ac_if.o_ac_valid), 64'd0);
            chk("rst_snoop_cnt", 64'(o_snoop_cnt), 64'd0);
            chk("rst_match_cnt", 64'(o_match_cnt), 64'd0);
        end else begin
            chk("acready", 64'(ac_if.acready), 64'(ready_m));
            chk("o_ac_valid", 64'(ac_if.o_ac_valid), 64'(mq.size() != 0));
            if (mq.size() != 0)
                chk("payload", 64'({ac_if.o_ac_addr, ac_if.o_ac_snoop, ac_if.o_ac_prot,
                                    ac_if.o_ac_match}), 64'(mq[0]));
            chk("snoop_cnt", 64'(o_snoop_cnt), 64'(scnt_m));
            chk("match_cnt", 64'(o_match_cnt), 64'(mcnt_m));
`ifdef DEVIL_AC_TRACE_EN
            chk("last_addr", 64'(o_last_match_addr), 64'(last_a_m));
            chk("last_snoop", 64'(o_last_match_snoop), 64'(last_s_m));
`endif
            // Advance the model to the state after the coming posedge
            fwd_m = (mq.size() != 0) && ac_if.i_ac_ready;
            acc_m = ready_m && ac_if.acvalid;
            m_m   = exp_match(ac_if.acaddr, ac_if.acsnoop);
            if (fwd_m) void'(mq.pop_front());
            if (acc_m) mq.push_back({ac_if.acaddr, ac_if.acsnoop, ac_if.acprot, m_m});
            ready_m = (mq.size() < 2);
            if (i_cnt_clr) begin
                scnt_m   = 0;
                mcnt_m   = 0;
                last_a_m = '0;
                last_s_m = '0;
            end else if (acc_m) begin
                if (scnt_m < CMAX) scnt_m++;
                if (m_m && mcnt_m < CMAX) mcnt_m++;
                if (m_m) begin
                    last_a_m = ac_if.acaddr;
                    last_s_m = ac_if.acsnoop;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn           = 1'b0;
        ac_if.acvalid    = 1'b0;
        ac_if.i_ac_ready = 1'b1;
        i_cnt_clr        = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    // One beat with the downstream always ready; checks the stored verdict
    task automatic send(input logic [AW-1:0] a, input logic [SW-1:0] s, input logic exp,
                        input string nm);
        int n = 0;
        ac_if.acvalid = 1'b1;
        ac_if.acaddr  = a;
        ac_if.acsnoop = s;
        ac_if.acprot  = 3'($urandom);
        while (!ac_if.acready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk({nm, "_timeout"}, 64'(ac_if.acready), 64'd1);
        tick();
        ac_if.acvalid = 1'b0;
        chk({nm, "_valid"}, 64'(ac_if.o_ac_valid), 64'd1);
        chk(nm, 64'(ac_if.o_ac_match), 64'(exp));
        tick();
    endtask

    logic        was_acc;
    logic [AW-1:0] next_a;

    initial begin
        resetn           = 1'b0;
        i_en             = 1'b1;
        i_acflt_en       = 1'b0;
        i_addrflt_en     = 1'b0;
        i_acsnoop_ref    = '0;
        i_base_addr      = '0;
        i_mem_size       = '0;
        i_cnt_clr        = 1'b0;
        ac_if.acvalid    = 1'b0;
        ac_if.acaddr     = '0;
        ac_if.acsnoop    = '0;
        ac_if.acprot     = '0;
        ac_if.i_ac_ready = 1'b1;
        repeat (3) tick();

        // Reset release with acvalid already held high
        ac_if.acvalid = 1'b1;
        ac_if.acaddr  = 44'h123;
        ac_if.acprot  = 3'd5;
        resetn        = 1'b1;
        tick();
        chk("rel_acready", 64'(ac_if.acready), 64'd1);
        tick();
        chk("rel_first_valid", 64'(ac_if.o_ac_valid), 64'd1);
        chk("rel_first_addr", 64'(ac_if.o_ac_addr), 64'h123);
        chk("rel_snoop_cnt", 64'(o_snoop_cnt), 64'd1);
        ac_if.acvalid = 1'b0;
        tick();

        // ACSNOOP filter
        i_acflt_en    = 1'b1;
        i_acsnoop_ref = 4'd1;
        do_reset();
        send(44'h40, 4'd1, 1'b1, "acflt_b0");
        send(44'h44, 4'd0, 1'b0, "acflt_b1");
        send(44'h48, 4'd1, 1'b1, "acflt_b2");
        chk("acflt_snoop_cnt", 64'(o_snoop_cnt), 64'd3);
        chk("acflt_match_cnt", 64'(o_match_cnt), 64'd2);

        // Address window, including both edges and an empty window
        i_acflt_en   = 1'b0;
        i_addrflt_en = 1'b1;
        i_base_addr  = 32'h10;
        i_mem_size   = 32'h100;
        do_reset();
        send(44'h0F, 4'd3, 1'b0, "win_below");
        send(44'h10, 4'd3, 1'b1, "win_base");
        send(44'h10F, 4'd3, 1'b1, "win_last");
        send(44'h110, 4'd3, 1'b0, "win_end");
        i_mem_size = 32'h0;
        send(44'h0F, 4'd3, 1'b0, "zero_below");
        send(44'h10, 4'd3, 1'b0, "zero_base");
        send(44'h10F, 4'd3, 1'b0, "zero_last");
        send(44'h110, 4'd3, 1'b0, "zero_end");
        chk("win_match_cnt", 64'(o_match_cnt), 64'd2);
        // Window crossing 4 GiB must not wrap
        i_base_addr = 32'hFFFF_FF00;
        i_mem_size  = 32'h200;
        send(44'h1_0000_0000, 4'd0, 1'b1, "win_4g_in");
        send(44'h1_0000_0100, 4'd0, 1'b0, "win_4g_out");
        i_en = 1'b0;
        send(44'h1_0000_0000, 4'd0, 1'b0, "en_off");
        i_en         = 1'b1;
        i_addrflt_en = 1'b0;

        // Downstream stall: two beats buffered, then drained in order
        do_reset();
        ac_if.i_ac_ready = 1'b0;
        ac_if.acvalid    = 1'b1;
        next_a           = 44'h1000;
        for (int i = 0; i < 5; i++) begin
            ac_if.acaddr = next_a;
            was_acc      = ac_if.acready;
            tick();
            if (was_acc) next_a++;
        end
        chk("stall_acready", 64'(ac_if.acready), 64'd0);
        chk("stall_head", 64'(ac_if.o_ac_addr), 64'h1000);
        chk("stall_snoop_cnt", 64'(o_snoop_cnt), 64'd2);
        ac_if.i_ac_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ac_if.acaddr = next_a;
            was_acc      = ac_if.acready;
            tick();
            if (was_acc) next_a++;
        end
        ac_if.acvalid = 1'b0;
        repeat (3) tick();
        chk("drain_count", 64'(o_snoop_cnt), 64'(next_a - 44'h1000));

        // Saturation and clear-over-increment
        do_reset();
        ac_if.acvalid = 1'b1;
        repeat (CMAX + 5) tick();
        chk("sat_snoop_cnt", 64'(o_snoop_cnt), 64'(CMAX));
        chk("sat_match_cnt", 64'(o_match_cnt), 64'(CMAX));
        i_cnt_clr = 1'b1;
        tick();
        i_cnt_clr     = 1'b0;
        ac_if.acvalid = 1'b0;
        chk("clr_snoop_cnt", 64'(o_snoop_cnt), 64'd0);
        chk("clr_match_cnt", 64'(o_match_cnt), 64'd0);
        repeat (2) tick();

        // Reset asserted while the buffer is full
        do_reset();
        ac_if.i_ac_ready = 1'b0;
        ac_if.acvalid    = 1'b1;
        repeat (3) tick();
        chk("full_acready", 64'(ac_if.acready), 64'd0);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(ac_if.o_ac_valid), 64'd0);
        chk("midrst_snoop_cnt", 64'(o_snoop_cnt), 64'd0);
        repeat (2) tick();
        resetn           = 1'b1;
        ac_if.i_ac_ready = 1'b1;
        tick();
        send(44'h777, 4'd2, 1'b1, "post_rst");
        chk("post_rst_cnt", 64'(o_snoop_cnt), 64'd1);

        // Randomized traffic with live register changes
        was_acc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!ac_if.acvalid || was_acc) begin
                ac_if.acvalid = ($urandom_range(0, 9) < 7);
                ac_if.acaddr  = ($urandom_range(0, 3) == 0) ? {12'($urandom), 32'($urandom)}
                                                            : 44'($urandom_range(0, 2047));
                ac_if.acsnoop = 4'($urandom);
                ac_if.acprot  = 3'($urandom);
            end
            ac_if.i_ac_ready = ($urandom_range(0, 9) < 6);
            i_cnt_clr        = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) begin
                i_en          = ($urandom_range(0, 9) != 0);
                i_acflt_en    = 1'($urandom);
                i_addrflt_en  = 1'($urandom);
                i_acsnoop_ref = 4'($urandom);
                i_base_addr   = 32'($urandom_range(0, 1023));
                i_mem_size    = ($urandom_range(0, 4) == 0) ? 32'd0
                                                            : 32'($urandom_range(1, 1023));
            end
            was_acc = ac_if.acvalid && ac_if.acready;
            tick();
        end
        ac_if.acvalid    = 1'b0;
        ac_if.i_ac_ready = 1'b1;
        i_cnt_clr        = 1'b0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
